// File: rtl/r5p_csr_mtrap.sv
// r5p_csr_mtrap: machine-mode CSR file and trap sequencer for an RV64 M-only core.
//
// It holds mstatus, misa, mie, mtvec, mscratch, mepc, mcause, mtval and mip.
// It also sequences trap entry, MRET and WFI sleep, and sends redirect targets
// to the fetch stage.
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   csr_ren/csr_wen/csr_op         CSR read/write request, op 01 write / 10 set / 11 clear
//   csr_adr/csr_wdt                CSR address and write data (or set/clear mask)
//   csr_rdt/csr_ill                combinational read data and illegal-access flag
//   ins_ret/ins_pc                 retire strobe (interrupt boundary) and current PC
//   exc_vld/exc_cau/exc_val        synchronous exception, cause code, mtval value
//   mret/wfi                       MRET / WFI executing
//   irq_mei/irq_mti/irq_msi        external, timer and software interrupt lines
//   trp_vld/trp_adr                one-cycle fetch redirect pulse and its target
//   stall                          core held while sleeping in WFI
module r5p_csr_mtrap #(
  parameter int          XLEN      = 64,
  parameter logic [63:0] MISA      = 64'h8000_0000_0000_1104,
  parameter logic [63:0] MTVEC_RST = 64'h0000_0000_8000_0000,
  parameter bit          VEC_EN    = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            csr_ren,
  input  logic            csr_wen,
  input  logic [1:0]      csr_op,
  input  logic [11:0]     csr_adr,
  input  logic [XLEN-1:0] csr_wdt,
  output logic [XLEN-1:0] csr_rdt,
  output logic            csr_ill,
  input  logic            ins_ret,
  input  logic [XLEN-1:0] ins_pc,
  input  logic            exc_vld,
  input  logic [5:0]      exc_cau,
  input  logic [XLEN-1:0] exc_val,
  input  logic            mret,
  input  logic            wfi,
  input  logic            irq_mei,
  input  logic            irq_mti,
  input  logic            irq_msi,
  output logic            trp_vld,
  output logic [XLEN-1:0] trp_adr,
  output logic            stall
);

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_WFI = 1'b1} state_t;

  state_t      state_r, state_nxt_s;
  logic        mst_mie_r, mst_mpie_r;
  logic [2:0]  mie_r;   // {MEIE, MTIE, MSIE}
  logic [2:0]  mip_r;   // {MEIP, MTIP, MSIP}, registered interrupt lines
  logic [63:0] mtvec_r, mscratch_r, mepc_r, mcause_r, mtval_r;

  logic        impl_s, wr_en_s, wfi_st_s, wake_s, ret_s, exc_s, irq_s, trap_s, mret_s;
  logic [2:0]  pend_s;
  logic [5:0]  int_code_s, code_s;
  logic [63:0] rdt_s, wval_s, trp_adr_s;
  logic        trp_vld_s;

  // Place the three interrupt bits at their mie/mip positions (11/7/3).
  function automatic logic [63:0] irq_to_csr(input logic [2:0] v);
    return {52'd0, v[2], 3'd0, v[1], 3'd0, v[0], 3'd0};
  endfunction

  // CSR read mux; an unmatched address is flagged as unimplemented.
  always_comb begin
    rdt_s  = 64'd0;
    impl_s = 1'b1;
    case (csr_adr)
      12'h300: rdt_s = {51'd0, 2'b11, 3'd0, mst_mpie_r, 3'd0, mst_mie_r, 3'd0};
      12'h301: rdt_s = MISA;
      12'h304: rdt_s = irq_to_csr(mie_r);
      12'h305: rdt_s = mtvec_r;
      12'h340: rdt_s = mscratch_r;
      12'h341: rdt_s = mepc_r;
      12'h342: rdt_s = mcause_r;
      12'h343: rdt_s = mtval_r;
      12'h344: rdt_s = irq_to_csr(mip_r);
      default: impl_s = 1'b0;
    endcase
  end

  assign csr_rdt = rdt_s;
  assign csr_ill = ((csr_ren | csr_wen) & ~impl_s) |
                   (csr_wen & (csr_op != 2'b00) & (csr_adr[11:10] == 2'b11));

  // New CSR value for write/set/clear, based on the currently visible value.
  always_comb begin
    case (csr_op)
      2'b01:   wval_s = csr_wdt;
      2'b10:   wval_s = rdt_s | csr_wdt;
      2'b11:   wval_s = rdt_s & ~csr_wdt;
      default: wval_s = rdt_s;
    endcase
  end

  // Trap decision. While sleeping, only a pending enabled interrupt matters and
  // the wake cycle counts as a retire boundary for the current PC.
  assign pend_s   = mie_r & mip_r;
  assign wfi_st_s = (state_r == ST_WFI);
  assign wake_s   = wfi_st_s & (|pend_s);
  assign ret_s    = wfi_st_s ? wake_s : ins_ret;
  assign exc_s    = ~wfi_st_s & exc_vld;
  assign irq_s    = ret_s & mst_mie_r & (|pend_s);
  assign trap_s   = exc_s | irq_s;
  assign mret_s   = ~wfi_st_s & mret & ~trap_s;
  assign wr_en_s  = csr_wen & (csr_op != 2'b00) & ~csr_ill & ~trap_s;
  assign code_s   = exc_s ? exc_cau : int_code_s;

  // Interrupt priority: external, then software, then timer.
  always_comb begin
    if (pend_s[2]) begin
      int_code_s = 6'd11;
    end else if (pend_s[0]) begin
      int_code_s = 6'd3;
    end else if (pend_s[1]) begin
      int_code_s = 6'd7;
    end else begin
      int_code_s = 6'd0;
    end
  end

  // Redirect target: trap vector (vectored offset only for interrupts) or mepc on MRET.
  always_comb begin
    trp_vld_s = 1'b0;
    trp_adr_s = 64'd0;
    if (trap_s) begin
      trp_vld_s = 1'b1;
      trp_adr_s = {mtvec_r[63:2], 2'b00};
      if (!exc_s && mtvec_r[0]) begin
        trp_adr_s = {mtvec_r[63:2], 2'b00} + {56'd0, int_code_s, 2'b00};
      end else begin
        trp_adr_s = {mtvec_r[63:2], 2'b00};
      end
    end else if (mret_s) begin
      trp_vld_s = 1'b1;
      trp_adr_s = mepc_r;
    end else begin
      trp_vld_s = 1'b0;
    end
  end

  assign trp_vld = trp_vld_s;
  assign trp_adr = trp_adr_s;
  assign stall   = wfi_st_s & ~wake_s;

  // WFI sleep state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_RUN;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // WFI next-state: sleep unless a trap is taken, wake on any enabled pending interrupt.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_RUN: begin
        if (wfi && !trap_s) state_nxt_s = ST_WFI;
        else                state_nxt_s = ST_RUN;
      end
      ST_WFI: begin
        if (wake_s) state_nxt_s = ST_RUN;
        else        state_nxt_s = ST_WFI;
      end
      default: state_nxt_s = ST_RUN;
    endcase
  end

  // CSR state. Later assignments take precedence: a CSR write, then MRET's
  // mstatus update, then trap entry (a trap discards the write entirely).
  always_ff @(posedge clk) begin
    if (rst) begin
      mst_mie_r  <= 1'b0;
      mst_mpie_r <= 1'b0;
      mie_r      <= 3'd0;
      mip_r      <= 3'd0;
      mtvec_r    <= MTVEC_RST;
      mscratch_r <= 64'd0;
      mepc_r     <= 64'd0;
      mcause_r   <= 64'd0;
      mtval_r    <= 64'd0;
    end else begin
      mip_r <= {irq_mei, irq_mti, irq_msi};
      if (wr_en_s) begin
        case (csr_adr)
          12'h300: begin
            mst_mie_r  <= wval_s[3];
            mst_mpie_r <= wval_s[7];
          end
          12'h304: mie_r      <= {wval_s[11], wval_s[7], wval_s[3]};
          12'h305: mtvec_r    <= {wval_s[63:2], 1'b0, (VEC_EN ? wval_s[0] : 1'b0)};
          12'h340: mscratch_r <= wval_s;
          12'h341: mepc_r     <= {wval_s[63:1], 1'b0};
          12'h342: mcause_r   <= wval_s;
          12'h343: mtval_r    <= wval_s;
          default: ;
        endcase
      end
      if (mret_s) begin
        mst_mie_r  <= mst_mpie_r;
        mst_mpie_r <= 1'b1;
      end
      if (trap_s) begin
        mepc_r     <= {ins_pc[63:1], 1'b0};
        mcause_r   <= {~exc_s, 57'd0, code_s};
        mtval_r    <= exc_s ? exc_val : 64'd0;
        mst_mpie_r <= mst_mie_r;
        mst_mie_r  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_r5p_csr_mtrap.sv
// Testbench for r5p_csr_mtrap: scoreboard of expected outputs pushed as each
// cycle's stimulus is driven, popped and compared on the falling edge.
module tb_r5p_csr_mtrap;

  localparam logic [63:0] MISA_V  = 64'h8000_0000_0000_1104;
  localparam logic [63:0] MTVEC_V = 64'h0000_0000_8000_0000;

  localparam int S_RDT   = 0;
  localparam int S_ILL   = 1;
  localparam int S_TVLD  = 2;
  localparam int S_TADR  = 3;
  localparam int S_STALL = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        csr_ren, csr_wen;
  logic [1:0]  csr_op;
  logic [11:0] csr_adr;
  logic [63:0] csr_wdt, csr_rdt;
  logic        csr_ill;
  logic        ins_ret;
  logic [63:0] ins_pc;
  logic        exc_vld;
  logic [5:0]  exc_cau;
  logic [63:0] exc_val;
  logic        mret, wfi;
  logic        irq_mei, irq_mti, irq_msi;
  logic        trp_vld;
  logic [63:0] trp_adr;
  logic        stall;

  typedef struct {
    string       tag;
    int          sel;
    logic [63:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks   = 0;
  int  failures = 0;

  always #5 clk = ~clk;

  r5p_csr_mtrap dut (
    .clk(clk), .rst(rst),
    .csr_ren(csr_ren), .csr_wen(csr_wen), .csr_op(csr_op), .csr_adr(csr_adr),
    .csr_wdt(csr_wdt), .csr_rdt(csr_rdt), .csr_ill(csr_ill),
    .ins_ret(ins_ret), .ins_pc(ins_pc),
    .exc_vld(exc_vld), .exc_cau(exc_cau), .exc_val(exc_val),
    .mret(mret), .wfi(wfi),
    .irq_mei(irq_mei), .irq_mti(irq_mti), .irq_msi(irq_msi),
    .trp_vld(trp_vld), .trp_adr(trp_adr), .stall(stall)
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] pick(input int sel);
    case (sel)
      S_RDT:   return csr_rdt;
      S_ILL:   return {63'd0, csr_ill};
      S_TVLD:  return {63'd0, trp_vld};
      S_TADR:  return trp_adr;
      default: return {63'd0, stall};
    endcase
  endfunction

  task automatic expect_out(input string tag, input int sel, input logic [63:0] exp);
    sb_t e;
    e.tag = tag;
    e.sel = sel;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic idle();
    csr_ren = 1'b0; csr_wen = 1'b0; csr_op = 2'b00; csr_adr = 12'h000; csr_wdt = 64'd0;
    ins_ret = 1'b0; ins_pc = 64'd0; exc_vld = 1'b0; exc_cau = 6'd0; exc_val = 64'd0;
    mret = 1'b0; wfi = 1'b0;
  endtask

  // One cycle: compare everything queued for it on the falling edge, then advance.
  task automatic step();
    @(negedge clk);
    while (sb_q.size() > 0) begin
      sb_t e;
      e = sb_q.pop_front();
      check_val(e.tag, pick(e.sel), e.exp);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic rd(input string tag, input logic [11:0] adr, input logic [63:0] exp);
    csr_ren = 1'b1;
    csr_adr = adr;
    expect_out(tag, S_RDT, exp);
    expect_out({tag, "_ill"}, S_ILL, 64'd0);
    step();
  endtask

  task automatic wr(input logic [11:0] adr, input logic [1:0] op, input logic [63:0] wdt);
    csr_wen = 1'b1;
    csr_adr = adr;
    csr_op  = op;
    csr_wdt = wdt;
    expect_out("wr_ill", S_ILL, 64'd0);
    step();
  endtask

  initial begin
    idle();
    irq_mei = 1'b0; irq_mti = 1'b0; irq_msi = 1'b0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    expect_out("rst_tvld", S_TVLD, 64'd0);
    expect_out("rst_tadr", S_TADR, 64'd0);
    expect_out("rst_stall", S_STALL, 64'd0);
    step();
    rd("rst_misa", 12'h301, MISA_V);
    rd("rst_mtvec", 12'h305, MTVEC_V);
    rd("rst_mstatus", 12'h300, 64'h1800);
    rd("rst_mie", 12'h304, 64'd0);
    wr(12'h304, 2'b01, ~64'd0);
    rd("mie_mask", 12'h304, 64'h888);
    wr(12'h304, 2'b11, 64'h80);
    rd("mie_clear", 12'h304, 64'h808);
    wr(12'h304, 2'b10, 64'h80);
    rd("mie_set", 12'h304, 64'h888);

    // Synchronous exception with MIE=1 beforehand
    wr(12'h300, 2'b10, 64'h8);
    rd("mst_mie1", 12'h300, 64'h1808);
    exc_vld = 1'b1; exc_cau = 6'd2; ins_pc = 64'h8000_0104; exc_val = 64'hDEAD;
    expect_out("exc_tvld", S_TVLD, 64'd1);
    expect_out("exc_tadr", S_TADR, 64'h8000_0000);
    step();
    rd("exc_mepc", 12'h341, 64'h8000_0104);
    rd("exc_mcause", 12'h342, 64'd2);
    rd("exc_mtval", 12'h343, 64'hDEAD);
    rd("exc_mstatus", 12'h300, 64'h1880);

    // Vectored interrupt: MEI beats MTI
    wr(12'h305, 2'b01, 64'h8000_0001);
    rd("mtvec_vec", 12'h305, 64'h8000_0001);
    wr(12'h300, 2'b10, 64'h8);
    irq_mti = 1'b1; irq_mei = 1'b1;
    expect_out("irq_noret", S_TVLD, 64'd0);
    step();
    ins_ret = 1'b1; ins_pc = 64'h8000_0200;
    expect_out("irq_tvld", S_TVLD, 64'd1);
    expect_out("irq_tadr", S_TADR, 64'h8000_002C);
    step();
    irq_mti = 1'b0; irq_mei = 1'b0;
    rd("irq_mcause", 12'h342, 64'h8000_0000_0000_000B);
    rd("irq_mepc", 12'h341, 64'h8000_0200);
    rd("irq_mtval", 12'h343, 64'd0);
    rd("irq_mstatus", 12'h300, 64'h1880);

    // MRET
    mret = 1'b1;
    expect_out("mret_tvld", S_TVLD, 64'd1);
    expect_out("mret_tadr", S_TADR, 64'h8000_0200);
    step();
    rd("mret_mstatus", 12'h300, 64'h1888);

    // Exception and MRET together: exception wins
    exc_vld = 1'b1; exc_cau = 6'd3; ins_pc = 64'h8000_0300; mret = 1'b1;
    expect_out("excmret_tvld", S_TVLD, 64'd1);
    expect_out("excmret_tadr", S_TADR, 64'h8000_0000);
    step();
    rd("excmret_mstatus", 12'h300, 64'h1880);
    rd("excmret_mepc", 12'h341, 64'h8000_0300);

    // WFI with MIE=0: wake without trap
    wfi = 1'b1;
    expect_out("wfi0_enter_stall", S_STALL, 64'd0);
    expect_out("wfi0_enter_tvld", S_TVLD, 64'd0);
    step();
    expect_out("wfi0_sleep", S_STALL, 64'd1);
    step();
    irq_mti = 1'b1;
    expect_out("wfi0_unreg", S_STALL, 64'd1);
    step();
    expect_out("wfi0_wake_stall", S_STALL, 64'd0);
    expect_out("wfi0_wake_tvld", S_TVLD, 64'd0);
    step();
    irq_mti = 1'b0;
    rd("wfi0_mcause", 12'h342, 64'd3);

    // WFI with MIE=1: trap taken in wake cycle
    wr(12'h300, 2'b10, 64'h8);
    wfi = 1'b1;
    expect_out("wfi1_enter_tvld", S_TVLD, 64'd0);
    step();
    expect_out("wfi1_sleep", S_STALL, 64'd1);
    step();
    irq_mti = 1'b1;
    expect_out("wfi1_unreg", S_STALL, 64'd1);
    step();
    ins_pc = 64'h8000_0400;
    expect_out("wfi1_wake_stall", S_STALL, 64'd0);
    expect_out("wfi1_wake_tvld", S_TVLD, 64'd1);
    expect_out("wfi1_wake_tadr", S_TADR, 64'h8000_001C);
    step();
    irq_mti = 1'b0;
    rd("wfi1_mcause", 12'h342, 64'h8000_0000_0000_0007);
    rd("wfi1_mepc", 12'h341, 64'h8000_0400);

    // Illegal accesses
    csr_wen = 1'b1; csr_op = 2'b01; csr_adr = 12'hF11; csr_wdt = 64'h5;
    expect_out("ill_wr_f11", S_ILL, 64'd1);
    step();
    csr_ren = 1'b1; csr_adr = 12'h7C0;
    expect_out("ill_rd_7c0", S_ILL, 64'd1);
    step();
    wr(12'h301, 2'b01, ~64'd0);
    rd("misa_warl", 12'h301, MISA_V);

    // Trap beats a concurrent mscratch write
    wr(12'h340, 2'b01, 64'h1234);
    rd("mscratch_wr", 12'h340, 64'h1234);
    csr_wen = 1'b1; csr_op = 2'b01; csr_adr = 12'h340; csr_wdt = 64'hFFFF;
    exc_vld = 1'b1; exc_cau = 6'd5; ins_pc = 64'h8000_0500;
    expect_out("trapwr_tvld", S_TVLD, 64'd1);
    step();
    rd("trapwr_mscratch", 12'h340, 64'h1234);

    // MRET with concurrent mepc write uses old mepc
    csr_wen = 1'b1; csr_op = 2'b01; csr_adr = 12'h341; csr_wdt = 64'h9000; mret = 1'b1;
    expect_out("mretwr_tadr", S_TADR, 64'h8000_0500);
    step();
    rd("mretwr_mepc", 12'h341, 64'h9000);

    // Write masks
    wr(12'h341, 2'b01, 64'h1235);
    rd("mepc_bit0", 12'h341, 64'h1234);
    wr(12'h300, 2'b01, ~64'd0);
    rd("mstatus_mask", 12'h300, 64'h1888);
    wr(12'h305, 2'b01, ~64'd0);
    rd("mtvec_mask", 12'h305, 64'hFFFF_FFFF_FFFF_FFFD);

    // Reset from a modified state
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd("rst2_mstatus", 12'h300, 64'h1800);
    rd("rst2_mtvec", 12'h305, MTVEC_V);
    rd("rst2_mie", 12'h304, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
